// File: rtl/hx8357_pkg.sv
// rtl/hx8357_pkg.sv - HX8357 opcodes, receiver state type and default panel ID
package hx8357_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_RDDID   = 8'h04;
    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    localparam logic [15:0] DEFAULT_ID = 16'h8357;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PARAM,
        ST_RAMWR
    } rx_state_t;

endpackage

// File: rtl/hx8357_bus_sync.sv
// rtl/hx8357_bus_sync.sv - 2-flop bus synchronizer with registered WRx rise event and RDx level
module hx8357_bus_sync #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         nres,
    input  logic         i_cs_n,
    input  logic         i_res_n,
    input  logic         i_dc,
    input  logic         i_wr_n,
    input  logic         i_rd_n,
    input  logic [W-1:0] i_data,
    output logic         o_res_n,
    output logic         o_wr_n,
    output logic         o_rd_active,
    output logic         o_wr_evt,
    output logic         o_evt_dc,
    output logic [W-1:0] o_evt_data
);

    localparam int SW = W + 5;
    localparam logic [SW-1:0] RST_VAL = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, {W{1'b0}}};

    logic [SW-1:0] r_s1;
    logic [SW-1:0] r_s2;
    logic          r_wr_prev;
    logic          r_wr_evt;
    logic          r_evt_dc;
    logic [W-1:0]  r_evt_data;
    logic          w_cs_n;
    logic          w_rd_n;
    logic          w_wr_rise;

    assign w_cs_n      = r_s2[W+4];
    assign o_res_n     = r_s2[W+3];
    assign o_wr_n      = r_s2[W+1];
    assign w_rd_n      = r_s2[W];
    assign o_rd_active = ~w_cs_n & ~w_rd_n;
    assign w_wr_rise   = o_wr_n & ~r_wr_prev & ~w_cs_n;

    assign o_wr_evt   = r_wr_evt;
    assign o_evt_dc   = r_evt_dc;
    assign o_evt_data = r_evt_data;

    // DCx/DATAx are frozen alongside the event so the decoder sees a coherent write
    always_ff @(posedge clk) begin
        if (!nres) begin
            r_s1       <= RST_VAL;
            r_s2       <= RST_VAL;
            r_wr_prev  <= 1'b1;
            r_wr_evt   <= 1'b0;
            r_evt_dc   <= 1'b0;
            r_evt_data <= '0;
        end else begin
            r_s1      <= {i_cs_n, i_res_n, i_dc, i_wr_n, i_rd_n, i_data};
            r_s2      <= r_s1;
            r_wr_prev <= o_wr_n;
            r_wr_evt  <= w_wr_rise;
            if (w_wr_rise) begin
                r_evt_dc   <= r_s2[W+2];
                r_evt_data <= r_s2[W-1:0];
            end
        end
    end

endmodule

// File: rtl/hx8357_bus_rx.sv
// rtl/hx8357_bus_rx.sv - HX8357 8080-bus panel responder; optional counters via HX8357_RX_STATS_EN
module hx8357_bus_rx
    import hx8357_pkg::*;
#(
    parameter int          H_RES    = 320,
    parameter int          V_RES    = 480,
    parameter logic [15:0] ID_VALUE = DEFAULT_ID
) (
    input  logic        clk,
    input  logic        nres,
    input  logic        CSx,
    input  logic        RESx,
    input  logic        DCx,
    input  logic        WRx,
    input  logic        RDx,
    input  logic [15:0] DATAx,
    output logic [15:0] rd_data,
    output logic        rd_oe,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        param_valid,
    output logic [15:0] param_data,
    output logic [3:0]  param_idx,
    output logic        pix_valid,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        disp_on,
    output logic        sleep,
`ifdef HX8357_RX_STATS_EN
    output logic [31:0] stat_cmds,
    output logic [31:0] stat_pix,
    output logic [31:0] stat_errs,
`endif
    output logic        proto_err
);

    logic        w_res_n, w_wr_n, w_rd_active, w_wr_evt, w_evt_dc;
    logic [15:0] w_evt_data;

    hx8357_bus_sync #(.W(16)) u_sync (
        .clk         (clk),
        .nres        (nres),
        .i_cs_n      (CSx),
        .i_res_n     (RESx),
        .i_dc        (DCx),
        .i_wr_n      (WRx),
        .i_rd_n      (RDx),
        .i_data      (DATAx),
        .o_res_n     (w_res_n),
        .o_wr_n      (w_wr_n),
        .o_rd_active (w_rd_active),
        .o_wr_evt    (w_wr_evt),
        .o_evt_dc    (w_evt_dc),
        .o_evt_data  (w_evt_data)
    );

    rx_state_t   r_state, w_state_nxt;
    logic        r_wr_block, r_conf_prev;
    logic [15:0] r_rd_data;
    logic        r_rd_oe, r_cmd_valid, r_param_valid, r_pix_valid, r_proto_err;
    logic [7:0]  r_cmd_code;
    logic [15:0] r_param_data, r_pix_data;
    logic [3:0]  r_param_idx;
    logic [8:0]  r_pix_x, r_pix_y, r_x, r_y, r_sc, r_ec, r_sp, r_ep;
    logic        r_disp_on, r_sleep;
    logic        r_b0, r_b2;
    logic [7:0]  r_b1;

    logic        w_conflict, w_wr_ok, w_is_cmd, w_is_dat, w_swreset, w_x_wrap, w_in_range;
    logic [7:0]  w_code;
    logic [8:0]  w_x_nxt, w_y_nxt;

    // A write whose low phase overlapped RDx low is discarded via r_wr_block
    assign w_conflict = w_rd_active & ~w_wr_n;
    assign w_wr_ok    = w_wr_evt & ~r_wr_block;
    assign w_is_cmd   = w_wr_ok & ~w_evt_dc;
    assign w_is_dat   = w_wr_ok & w_evt_dc;
    assign w_code     = w_evt_data[7:0];
    assign w_swreset  = w_is_cmd & (w_code == CMD_SWRESET);

    assign w_x_wrap   = (r_x == r_ec) || (r_ec < r_sc);
    assign w_x_nxt    = w_x_wrap ? r_sc : r_x + 9'd1;
    assign w_y_nxt    = !w_x_wrap ? r_y : ((r_y == r_ep) ? r_sp : r_y + 9'd1);
    assign w_in_range = ({1'b0, r_x} < 10'(H_RES)) && ({1'b0, r_y} < 10'(V_RES));

    always_comb begin
        w_state_nxt = r_state;
        if (w_is_cmd) begin
            case (w_code)
                CMD_CASET, CMD_PASET:                    w_state_nxt = ST_PARAM;
                CMD_RAMWR:                               w_state_nxt = ST_RAMWR;
                CMD_DISPON, CMD_DISPOFF, CMD_SLPOUT,
                CMD_SLPIN, CMD_SWRESET:                  w_state_nxt = ST_IDLE;
                default:                                 w_state_nxt = ST_PARAM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nres || !w_res_n || w_swreset) r_state <= ST_IDLE;
        else                                r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!nres || !w_res_n || w_swreset) begin
            r_cmd_valid   <= w_swreset & w_res_n;
            r_cmd_code    <= (w_swreset & w_res_n) ? CMD_SWRESET : 8'h00;
            r_wr_block    <= 1'b0;
            r_conf_prev   <= 1'b0;
            r_rd_oe       <= 1'b0;
            r_rd_data     <= '0;
            r_param_valid <= 1'b0;
            r_param_data  <= '0;
            r_param_idx   <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_data    <= '0;
            r_proto_err   <= 1'b0;
            r_disp_on     <= 1'b0;
            r_sleep       <= 1'b1;
            r_x           <= '0;
            r_y           <= '0;
            r_sc          <= '0;
            r_ec          <= 9'(H_RES - 1);
            r_sp          <= '0;
            r_ep          <= 9'(V_RES - 1);
            r_b0          <= 1'b0;
            r_b1          <= '0;
            r_b2          <= 1'b0;
        end else begin
            r_cmd_valid   <= 1'b0;
            r_param_valid <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_proto_err   <= (w_conflict & ~r_conf_prev) | (w_is_dat & (r_state == ST_IDLE));
            r_conf_prev   <= w_conflict;
            r_wr_block    <= w_wr_evt ? w_conflict : (r_wr_block | w_conflict);
            r_rd_oe       <= w_rd_active & w_wr_n;
            r_rd_data     <= (w_rd_active & w_wr_n & (r_cmd_code == CMD_RDDID)) ? ID_VALUE : 16'h0000;
            if (r_param_valid && r_param_idx != 4'hF)
                r_param_idx <= r_param_idx + 4'd1;

            if (w_is_cmd) begin
                r_cmd_valid <= 1'b1;
                r_cmd_code  <= w_code;
                r_param_idx <= '0;
                case (w_code)
                    CMD_DISPON:  r_disp_on <= 1'b1;
                    CMD_DISPOFF: r_disp_on <= 1'b0;
                    CMD_SLPOUT:  r_sleep   <= 1'b0;
                    CMD_SLPIN:   r_sleep   <= 1'b1;
                    CMD_RAMWR: begin
                        r_x <= r_sc;
                        r_y <= r_sp;
                    end
                    default: ;
                endcase
            end else if (w_is_dat && r_state == ST_PARAM) begin
                r_param_valid <= 1'b1;
                r_param_data  <= w_evt_data;
                if (r_cmd_code == CMD_CASET || r_cmd_code == CMD_PASET) begin
                    case (r_param_idx)
                        4'd0: r_b0 <= w_code[0];
                        4'd1: r_b1 <= w_code;
                        4'd2: r_b2 <= w_code[0];
                        4'd3: begin
                            if (r_cmd_code == CMD_CASET) begin
                                r_sc <= {r_b0, r_b1};
                                r_ec <= {r_b2, w_code};
                            end else begin
                                r_sp <= {r_b0, r_b1};
                                r_ep <= {r_b2, w_code};
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (w_is_dat && r_state == ST_RAMWR) begin
                r_pix_valid <= w_in_range;
                r_pix_x     <= r_x;
                r_pix_y     <= r_y;
                r_pix_data  <= w_evt_data;
                r_x         <= w_x_nxt;
                r_y         <= w_y_nxt;
            end
        end
    end

`ifdef HX8357_RX_STATS_EN
    logic [31:0] r_stat_cmds, r_stat_pix, r_stat_errs;

    always_ff @(posedge clk) begin
        if (!nres || !w_res_n || w_swreset) begin
            r_stat_cmds <= '0;
            r_stat_pix  <= '0;
            r_stat_errs <= '0;
        end else begin
            if (r_cmd_valid && r_stat_cmds != '1) r_stat_cmds <= r_stat_cmds + 32'd1;
            if (r_pix_valid && r_stat_pix  != '1) r_stat_pix  <= r_stat_pix + 32'd1;
            if (r_proto_err && r_stat_errs != '1) r_stat_errs <= r_stat_errs + 32'd1;
        end
    end

    assign stat_cmds = r_stat_cmds;
    assign stat_pix  = r_stat_pix;
    assign stat_errs = r_stat_errs;
`endif

    assign rd_data     = r_rd_data;
    assign rd_oe       = r_rd_oe;
    assign cmd_valid   = r_cmd_valid;
    assign cmd_code    = r_cmd_code;
    assign param_valid = r_param_valid;
    assign param_data  = r_param_data;
    assign param_idx   = r_param_idx;
    assign pix_valid   = r_pix_valid;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pix_data    = r_pix_data;
    assign disp_on     = r_disp_on;
    assign sleep       = r_sleep;
    assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_hx8357_bus_rx.sv
// tb/tb_hx8357_bus_rx.sv - directed self-checking bench for hx8357_bus_rx
module tb_hx8357_bus_rx;

    logic        clk = 1'b0;
    logic        nres = 1'b0;
    logic        CSx = 1'b0, RESx = 1'b1, DCx = 1'b0, WRx = 1'b1, RDx = 1'b1;
    logic [15:0] DATAx = '0;
    logic [15:0] rd_data, param_data, pix_data;
    logic        rd_oe, cmd_valid, param_valid, pix_valid, disp_on, sleep, proto_err;
    logic [7:0]  cmd_code;
    logic [3:0]  param_idx;
    logic [8:0]  pix_x, pix_y;

    hx8357_bus_rx dut (
        .clk(clk), .nres(nres), .CSx(CSx), .RESx(RESx), .DCx(DCx), .WRx(WRx), .RDx(RDx),
        .DATAx(DATAx), .rd_data(rd_data), .rd_oe(rd_oe), .cmd_valid(cmd_valid),
        .cmd_code(cmd_code), .param_valid(param_valid), .param_data(param_data),
        .param_idx(param_idx), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_data(pix_data), .disp_on(disp_on), .sleep(sleep), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        sn_e2_cmd, sn_cmd_valid, sn_param_valid, sn_pix_valid, sn_proto;
    logic [7:0]  sn_cmd_code;
    logic [3:0]  sn_param_idx;
    logic [15:0] sn_param_data, sn_pix_data;
    logic [8:0]  sn_pix_x, sn_pix_y;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Snapshot outputs 2 and 3 edges after the first edge that samples WRx high
    task automatic bus_write(input logic dc, input logic [15:0] d);
        @(negedge clk);
        DCx = dc;
        DATAx = d;
        WRx = 1'b0;
        repeat (4) @(negedge clk);
        WRx = 1'b1;
        repeat (3) @(posedge clk);
        #1 sn_e2_cmd = cmd_valid;
        @(posedge clk);
        #1;
        sn_cmd_valid   = cmd_valid;
        sn_cmd_code    = cmd_code;
        sn_param_valid = param_valid;
        sn_param_idx   = param_idx;
        sn_param_data  = param_data;
        sn_pix_valid   = pix_valid;
        sn_pix_x       = pix_x;
        sn_pix_y       = pix_y;
        sn_pix_data    = pix_data;
        sn_proto       = proto_err;
        repeat (3) @(negedge clk);
    endtask

    task automatic read_check(input string tag, input logic [15:0] exp);
        @(negedge clk);
        RDx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_oe"}, 32'(rd_oe), 32'd1);
        check({tag, "_data"}, 32'(rd_data), 32'(exp));
        repeat (4) @(negedge clk);
        RDx = 1'b1;
        repeat (4) @(posedge clk);
        #1 check({tag, "_release"}, 32'(rd_oe), 32'd0);
    endtask

    logic [8:0]  exp_x[5];
    logic [8:0]  exp_y[5];
    logic        exp_v[5];
    int          n_err, n_cmd, n_oe;

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_code", 32'(cmd_code), 32'd0);
        check("rst_sleep", 32'(sleep), 32'd1);
        check("rst_disp_on", 32'(disp_on), 32'd0);
        check("rst_rd_oe", 32'(rd_oe), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        nres = 1'b1;
        repeat (3) @(negedge clk);

        bus_write(1'b0, 16'h0011);
        check("slpout_e2_no_pulse", 32'(sn_e2_cmd), 32'd0);
        check("slpout_e3_pulse", 32'(sn_cmd_valid), 32'd1);
        check("slpout_code", 32'(sn_cmd_code), 32'h11);
        check("slpout_sleep", 32'(sleep), 32'd0);
        bus_write(1'b0, 16'h0029);
        check("dispon", 32'(disp_on), 32'd1);

        bus_write(1'b0, 16'h002A);
        bus_write(1'b1, 16'h0000);
        check("caset2_p0_idx", 32'(sn_param_idx), 32'd0);
        check("caset2_p0_valid", 32'(sn_param_valid), 32'd1);
        bus_write(1'b1, 16'h0005);
        check("caset2_p1_idx", 32'(sn_param_idx), 32'd1);
        bus_write(1'b0, 16'h002C);
        bus_write(1'b1, 16'h1234);
        check("nocommit_valid", 32'(sn_pix_valid), 32'd1);
        check("nocommit_x", 32'(sn_pix_x), 32'd0);
        check("nocommit_y", 32'(sn_pix_y), 32'd0);
        check("nocommit_data", 32'(sn_pix_data), 32'h1234);

        bus_write(1'b0, 16'h002A);
        bus_write(1'b1, 16'h0000);
        bus_write(1'b1, 16'h000A);
        bus_write(1'b1, 16'h0000);
        bus_write(1'b1, 16'h000B);
        check("caset_p3_idx", 32'(sn_param_idx), 32'd3);
        check("caset_p3_data", 32'(sn_param_data), 32'h000B);
        bus_write(1'b0, 16'h002B);
        bus_write(1'b1, 16'h0000);
        bus_write(1'b1, 16'h0014);
        bus_write(1'b1, 16'h0000);
        bus_write(1'b1, 16'h0015);
        bus_write(1'b0, 16'h002C);
        exp_x = '{9'd10, 9'd11, 9'd10, 9'd11, 9'd10};
        exp_y = '{9'd20, 9'd20, 9'd21, 9'd21, 9'd20};
        for (int i = 0; i < 5; i++) begin
            bus_write(1'b1, 16'hF800 + 16'(i));
            check($sformatf("win_valid%0d", i), 32'(sn_pix_valid), 32'd1);
            check($sformatf("win_x%0d", i), 32'(sn_pix_x), 32'(exp_x[i]));
            check($sformatf("win_y%0d", i), 32'(sn_pix_y), 32'(exp_y[i]));
        end
        check("win_data4", 32'(sn_pix_data), 32'hF804);

        bus_write(1'b0, 16'h002A);
        bus_write(1'b1, 16'h0001);
        bus_write(1'b1, 16'h003E);
        bus_write(1'b1, 16'h0001);
        bus_write(1'b1, 16'h0041);
        bus_write(1'b0, 16'h002C);
        exp_v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_x = '{9'd318, 9'd319, 9'd320, 9'd321, 9'd318};
        exp_y = '{9'd20, 9'd20, 9'd20, 9'd20, 9'd21};
        for (int i = 0; i < 5; i++) begin
            bus_write(1'b1, 16'h07E0);
            check($sformatf("edge_valid%0d", i), 32'(sn_pix_valid), 32'(exp_v[i]));
            if (exp_v[i]) begin
                check($sformatf("edge_x%0d", i), 32'(sn_pix_x), 32'(exp_x[i]));
                check($sformatf("edge_y%0d", i), 32'(sn_pix_y), 32'(exp_y[i]));
            end
        end

        bus_write(1'b0, 16'h0004);
        read_check("rddid", 16'h8357);
        bus_write(1'b0, 16'h0009);
        read_check("rd_other", 16'h0000);

        @(negedge clk);
        DCx = 1'b0;
        DATAx = 16'h0028;
        WRx = 1'b0;
        RDx = 1'b0;
        n_err = 0; n_cmd = 0; n_oe = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 4) begin
                WRx = 1'b1;
                RDx = 1'b1;
            end
            n_err += int'(proto_err);
            n_cmd += int'(cmd_valid);
            n_oe  += int'(rd_oe);
        end
        check("conflict_proto_err", 32'(n_err), 32'd1);
        check("conflict_no_cmd", 32'(n_cmd), 32'd0);
        check("conflict_no_oe", 32'(n_oe), 32'd0);
        check("conflict_disp_kept", 32'(disp_on), 32'd1);

        bus_write(1'b0, 16'h002C);
        bus_write(1'b1, 16'hABCD);
        check("pre_resx_pix", 32'(sn_pix_valid), 32'd1);
        @(negedge clk);
        RESx = 1'b0;
        repeat (5) @(negedge clk);
        RESx = 1'b1;
        repeat (4) @(negedge clk);
        check("resx_disp_on", 32'(disp_on), 32'd0);
        check("resx_sleep", 32'(sleep), 32'd1);
        bus_write(1'b1, 16'h1111);
        check("resx_idle_proto", 32'(sn_proto), 32'd1);
        check("resx_idle_nopix", 32'(sn_pix_valid), 32'd0);
        bus_write(1'b0, 16'h002C);
        bus_write(1'b1, 16'h2222);
        check("resx_win_valid", 32'(sn_pix_valid), 32'd1);
        check("resx_win_x", 32'(sn_pix_x), 32'd0);
        check("resx_win_y", 32'(sn_pix_y), 32'd0);

        bus_write(1'b0, 16'h0011);
        check("pre_swreset_sleep", 32'(sleep), 32'd0);
        bus_write(1'b0, 16'h0001);
        check("swreset_cmd_valid", 32'(sn_cmd_valid), 32'd1);
        check("swreset_code", 32'(sn_cmd_code), 32'h01);
        check("swreset_sleep", 32'(sleep), 32'd1);
        bus_write(1'b1, 16'h3333);
        check("swreset_idle_proto", 32'(sn_proto), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
